mem_write_arb: RTL and testbench
================================

// Module: mem_write_arb
// PURPOSE
//  Write-port arbiter between spi_debug_ifc / cpu and the shared memory write bus (sram, vram, ctrl).
//  CPU writes always win and are never dropped; debug writes queue in a small FIFO and drain on cycles with no CPU write.
//  Replaces the combinational "debug wins" mux; the merged bus leaves a register stage.
// PARAMETERS
//  AWIDTH      16  address width of both sources and the merged bus
//  DWIDTH      16  data width of both sources and the merged bus
//  DEPTH_LOG2  2   debug FIFO depth = 2**DEPTH_LOG2 entries (4)
// PORTS
//  clk           in   1           system clock (25 MHz domain, same as cpu and spi_debug_ifc sys side)
//  reset_n       in   1           asynchronous, active-low reset
//  cpu_we_i      in   1           cpu write strobe, one write per cycle when high
//  cpu_waddr_i   in   AWIDTH      cpu write address
//  cpu_wdata_i   in   DWIDTH      cpu write data
//  dbg_we_i      in   1           debug write strobe (single-cycle pulses from spi_debug_ifc)
//  dbg_waddr_i   in   AWIDTH      debug write address
//  dbg_wdata_i   in   DWIDTH      debug write data
//  ovf_clr_i     in   1           clears overflow_o
//  we_o          out  1           merged write strobe (registered)
//  waddr_o       out  AWIDTH      merged write address (registered)
//  wdata_o       out  DWIDTH      merged write data (registered)
//  src_dbg_o     out  1           1 = current we_o beat came from the debug FIFO
//  fifo_level_o  out  DEPTH_LOG2+1  debug FIFO occupancy, 0..2**DEPTH_LOG2
//  overflow_o    out  1           sticky: a debug write was dropped
// BEHAVIOUR
//  - Reset (reset_n low, async): we_o=0, waddr_o=0, wdata_o=0, src_dbg_o=0, fifo_level_o=0, overflow_o=0; FIFO pointers 0.
//  - CPU path: cpu_we_i high in cycle N -> we_o/waddr_o/wdata_o show it in cycle N+1, src_dbg_o=0. Latency exactly 1.
//  - Debug push: dbg_we_i high in cycle N and FIFO not full (or a pop in the same cycle) -> entry written at edge ending N.
//  - Debug pop: in any cycle with cpu_we_i low and level>0, head entry drives merged regs next cycle, src_dbg_o=1.
//    Minimum debug latency 2 cycles (push edge, then pop edge). Order of debug writes preserved.
//  - No write source in a cycle: we_o=0 next cycle; waddr_o/wdata_o hold previous values.
//  - Simultaneous push+pop: both happen, level unchanged; allowed at full and at empty+... (empty: pop needs level>0, so push only).
//  - Full (level==2**DEPTH_LOG2), push without pop: write dropped, overflow_o set next cycle, level unchanged.
//  - overflow_o clears only on ovf_clr_i or reset; set wins if ovf_clr_i and a drop coincide.
//  - Sustained cpu_we_i starves debug; FIFO fills then drops — accepted, visible via overflow_o.
//  - Pointers: DEPTH_LOG2-bit read/write indices wrap modulo depth; level is a separate DEPTH_LOG2+1-bit counter.
//  - Reset mid-burst: queued debug writes discarded, no partial beat emitted.
//  - Note: CPU read-after-write to same address now needs one extra cycle; cpu must tolerate this (it issues no back-to-back RAW).
// CONFIGURATION
//  MEM_WRITE_ARB_STATS_EN defined: adds outputs dbg_drop_cnt_o[15:0] (saturating count of dropped debug writes)
//   and cpu_block_cnt_o[15:0] (saturating count of cycles with level>0 and cpu_we_i high); both reset to 0, cleared by ovf_clr_i.
//  Not defined: those ports and counters do not exist; all other behaviour identical.
// STRUCTURE
//  - mem_bus_defs.vh (shared include): MEM_AWIDTH=16, MEM_DWIDTH=16, region codes on waddr[15:12]
//    (SRAM=4'h0, VRAM=4'h8, CTRL=4'hF), used by this block, top and the region decode.
//  - Sub-module wr_fifo: sync FIFO, width AWIDTH+DWIDTH, depth 2**DEPTH_LOG2, push/pop/full/empty/level, async active-low reset.
//  - This module: push/pop control, overflow flag, merged output register, optional stats counters.
// TESTING
//  1 cpu_we_i=1 addr 0x0010 data 0xBEEF, one cycle -> next cycle we_o=1 waddr_o=0x0010 wdata_o=0xBEEF src_dbg_o=0.
//  2 idle cpu, dbg pulse addr 0x8005 data 0x0041 -> we_o=1 two cycles later, src_dbg_o=1, fifo_level_o back to 0.
//  3 cpu_we_i held 8 cycles, 3 dbg pulses during it -> 8 cpu beats back-to-back, then 3 dbg beats in order, level peaks 3.
//  4 cpu_we_i held, 5 dbg pulses -> level=4, 5th dropped, overflow_o=1 (stats: dbg_drop_cnt_o=1); ovf_clr_i clears it.
//  5 FIFO full, cpu_we_i low, dbg pulse same cycle as pop -> accepted, level stays 4, no overflow.
//  6 reset_n low with level=3 mid-drain -> all outputs 0 immediately; after release no debug beat appears.

Source files
------------

// File: rtl/mem_write_arb_pkg.sv
// ---------------------------------------------------------------------------
// mem_write_arb_pkg
// Shared definitions for the memory write bus and the write-port arbiter:
//   - default address/data widths of the merged write bus
//   - region codes carried on waddr[15:12]
//   - source-select enum used by the arbiter's output register
//   - helper that extracts the region code from a bus address
// ---------------------------------------------------------------------------
package mem_write_arb_pkg;

    localparam int MEM_AWIDTH = 16;
    localparam int MEM_DWIDTH = 16;

    // Region codes live in the top nibble of every bus address.
    localparam logic [3:0] REGION_SRAM = 4'h0;
    localparam logic [3:0] REGION_VRAM = 4'h8;
    localparam logic [3:0] REGION_CTRL = 4'hF;

    // Which source drives the merged bus in the next cycle.
    typedef enum logic [1:0] {
        SEL_NONE = 2'd0,
        SEL_CPU  = 2'd1,
        SEL_DBG  = 2'd2
    } wr_sel_e;

    function automatic logic [3:0] region_of(input logic [MEM_AWIDTH-1:0] addr);
        return addr[MEM_AWIDTH-1 -: 4];
    endfunction

endpackage

// File: rtl/mem_write_arb_wr_fifo.sv
// ---------------------------------------------------------------------------
// wr_fifo
// Small synchronous FIFO holding queued debug writes ({addr, data} entries).
// Ports:
//   clk, reset_n     clock and asynchronous active-low reset
//   push, wdata      write an entry (ignored when full unless popping too)
//   pop, rdata       remove the head entry; rdata always shows the head
//   full, empty      occupancy flags
//   level            occupancy 0..2**DEPTH_LOG2
// ---------------------------------------------------------------------------
module wr_fifo #(
    parameter int WIDTH      = 32,
    parameter int DEPTH_LOG2 = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  push,
    input  logic [WIDTH-1:0]      wdata,
    input  logic                  pop,
    output logic [WIDTH-1:0]      rdata,
    output logic                  full,
    output logic                  empty,
    output logic [DEPTH_LOG2:0]   level
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [WIDTH-1:0]      mem [DEPTH];
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic                  do_push;
    logic                  do_pop;

    assign full  = (level == (DEPTH_LOG2+1)'(DEPTH));
    assign empty = (level == '0);
    assign rdata = mem[rd_ptr];

    // A push into a full FIFO is only legal when the head leaves in the same cycle.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // Storage needs no reset: an entry is only visible after it was written.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointers wrap naturally modulo the depth; level is kept separately so
    // full and empty are unambiguous.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (do_push && !do_pop) begin
                level <= level + 1'b1;
            end else if (do_pop && !do_push) begin
                level <= level - 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_write_arb.sv
// ---------------------------------------------------------------------------
// mem_write_arb
// Arbitrates the shared memory write bus between the cpu and spi_debug_ifc.
// CPU writes always win and reach the bus one cycle later; debug writes are
// queued in a small FIFO and drained in order on cycles without a CPU write.
// The merged bus is driven from registers.
//
// Ports:
//   clk, reset_n                      clock, asynchronous active-low reset
//   cpu_we_i/cpu_waddr_i/cpu_wdata_i  cpu write request
//   dbg_we_i/dbg_waddr_i/dbg_wdata_i  debug write request (single-cycle pulses)
//   ovf_clr_i                         clears overflow_o (and stats counters)
//   we_o/waddr_o/wdata_o              merged registered write bus
//   src_dbg_o                         current beat came from the debug FIFO
//   fifo_level_o                      debug FIFO occupancy
//   overflow_o                        sticky: a debug write was dropped
//
// Optional build macro MEM_WRITE_ARB_STATS_EN adds:
//   dbg_drop_cnt_o   saturating count of dropped debug writes
//   cpu_block_cnt_o  saturating count of cycles where the cpu held off a
//                    non-empty debug queue
// ---------------------------------------------------------------------------
module mem_write_arb
    import mem_write_arb_pkg::*;
#(
    parameter int AWIDTH     = MEM_AWIDTH,
    parameter int DWIDTH     = MEM_DWIDTH,
    parameter int DEPTH_LOG2 = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  cpu_we_i,
    input  logic [AWIDTH-1:0]     cpu_waddr_i,
    input  logic [DWIDTH-1:0]     cpu_wdata_i,
    input  logic                  dbg_we_i,
    input  logic [AWIDTH-1:0]     dbg_waddr_i,
    input  logic [DWIDTH-1:0]     dbg_wdata_i,
    input  logic                  ovf_clr_i,
    output logic                  we_o,
    output logic [AWIDTH-1:0]     waddr_o,
    output logic [DWIDTH-1:0]     wdata_o,
    output logic                  src_dbg_o,
    output logic [DEPTH_LOG2:0]   fifo_level_o,
    output logic                  overflow_o
`ifdef MEM_WRITE_ARB_STATS_EN
    ,
    output logic [15:0]           dbg_drop_cnt_o,
    output logic [15:0]           cpu_block_cnt_o
`endif
);

    localparam int EW = AWIDTH + DWIDTH;

    logic          fifo_full;
    logic          fifo_empty;
    logic          fifo_push;
    logic          fifo_pop;
    logic          dbg_drop;
    logic [EW-1:0] fifo_head;
    wr_sel_e       sel;

    // The FIFO is drained whenever the cpu leaves the bus free.
    assign fifo_pop  = !cpu_we_i && !fifo_empty;
    assign fifo_push = dbg_we_i && (!fifo_full || fifo_pop);
    assign dbg_drop  = dbg_we_i && fifo_full && !fifo_pop;

    wr_fifo #(
        .WIDTH      (EW),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (fifo_push),
        .wdata   ({dbg_waddr_i, dbg_wdata_i}),
        .pop     (fifo_pop),
        .rdata   (fifo_head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (fifo_level_o)
    );

    always_comb begin
        sel = SEL_NONE;
        if (cpu_we_i) begin
            sel = SEL_CPU;
        end else if (fifo_pop) begin
            sel = SEL_DBG;
        end
    end

    // Merged output register: address/data hold their last value on idle
    // cycles so the bus only toggles when a write actually happens.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            we_o      <= 1'b0;
            waddr_o   <= '0;
            wdata_o   <= '0;
            src_dbg_o <= 1'b0;
        end else begin
            case (sel)
                SEL_CPU: begin
                    we_o      <= 1'b1;
                    waddr_o   <= cpu_waddr_i;
                    wdata_o   <= cpu_wdata_i;
                    src_dbg_o <= 1'b0;
                end
                SEL_DBG: begin
                    we_o      <= 1'b1;
                    waddr_o   <= fifo_head[EW-1 -: AWIDTH];
                    wdata_o   <= fifo_head[DWIDTH-1:0];
                    src_dbg_o <= 1'b1;
                end
                default: begin
                    we_o      <= 1'b0;
                    src_dbg_o <= 1'b0;
                end
            endcase
        end
    end

    // Sticky overflow flag; a drop in the same cycle as a clear keeps it set.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            overflow_o <= 1'b0;
        end else if (dbg_drop) begin
            overflow_o <= 1'b1;
        end else if (ovf_clr_i) begin
            overflow_o <= 1'b0;
        end
    end

`ifdef MEM_WRITE_ARB_STATS_EN
    logic cpu_block;

    assign cpu_block = cpu_we_i && !fifo_empty;

    // Saturating statistics counters; a clear restarts counting from the
    // current cycle's event so nothing coincident is lost.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dbg_drop_cnt_o  <= '0;
            cpu_block_cnt_o <= '0;
        end else if (ovf_clr_i) begin
            dbg_drop_cnt_o  <= {15'd0, dbg_drop};
            cpu_block_cnt_o <= {15'd0, cpu_block};
        end else begin
            if (dbg_drop && (dbg_drop_cnt_o != 16'hFFFF)) begin
                dbg_drop_cnt_o <= dbg_drop_cnt_o + 16'd1;
            end
            if (cpu_block && (cpu_block_cnt_o != 16'hFFFF)) begin
                cpu_block_cnt_o <= cpu_block_cnt_o + 16'd1;
            end
        end
    end
`else
    // Statistics hardware is not built in this configuration.
`endif

endmodule

// File: tb/tb_mem_write_arb.sv
// ---------------------------------------------------------------------------
// tb_mem_write_arb
// Directed bench for mem_write_arb. A queue-based model of the arbiter
// predicts the merged bus every cycle; literal expectations pin key points
// of each scenario.
// ---------------------------------------------------------------------------
module tb_mem_write_arb;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        cpu_we = 1'b0;
    logic [15:0] cpu_waddr = '0;
    logic [15:0] cpu_wdata = '0;
    logic        dbg_we = 1'b0;
    logic [15:0] dbg_waddr = '0;
    logic [15:0] dbg_wdata = '0;
    logic        ovf_clr = 1'b0;
    logic        we;
    logic [15:0] waddr;
    logic [15:0] wdata;
    logic        src_dbg;
    logic [2:0]  fifo_level;
    logic        overflow;
`ifdef MEM_WRITE_ARB_STATS_EN
    logic [15:0] dbg_drop_cnt;
    logic [15:0] cpu_block_cnt;
`endif

    int checks = 0;
    int errors = 0;

    mem_write_arb dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .cpu_we_i     (cpu_we),
        .cpu_waddr_i  (cpu_waddr),
        .cpu_wdata_i  (cpu_wdata),
        .dbg_we_i     (dbg_we),
        .dbg_waddr_i  (dbg_waddr),
        .dbg_wdata_i  (dbg_wdata),
        .ovf_clr_i    (ovf_clr),
        .we_o         (we),
        .waddr_o      (waddr),
        .wdata_o      (wdata),
        .src_dbg_o    (src_dbg),
        .fifo_level_o (fifo_level),
        .overflow_o   (overflow)
`ifdef MEM_WRITE_ARB_STATS_EN
        ,
        .dbg_drop_cnt_o  (dbg_drop_cnt),
        .cpu_block_cnt_o (cpu_block_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Reference model: cpu beat wins, otherwise oldest queued debug write;
    // a debug write is queued if there is room after this cycle's pop.
    logic [31:0] q[$];
    logic        m_we = 1'b0;
    logic [15:0] m_addr = '0;
    logic [15:0] m_data = '0;
    logic        m_src = 1'b0;
    logic        m_ovf = 1'b0;

    always @(posedge clk or negedge reset_n) begin
        logic [31:0] e;
        logic        dropped;
        if (!reset_n) begin
            q.delete();
            m_we = 1'b0;
            m_addr = '0;
            m_data = '0;
            m_src = 1'b0;
            m_ovf = 1'b0;
        end else begin
            if (cpu_we) begin
                m_we = 1'b1;
                m_addr = cpu_waddr;
                m_data = cpu_wdata;
                m_src = 1'b0;
            end else if (q.size() > 0) begin
                e = q.pop_front();
                m_we = 1'b1;
                m_addr = e[31:16];
                m_data = e[15:0];
                m_src = 1'b1;
            end else begin
                m_we = 1'b0;
                m_src = 1'b0;
            end
            dropped = 1'b0;
            if (dbg_we) begin
                if (q.size() < 4) q.push_back({dbg_waddr, dbg_wdata});
                else dropped = 1'b1;
            end
            if (dropped) m_ovf = 1'b1;
            else if (ovf_clr) m_ovf = 1'b0;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Every cycle, away from the active edge, compare the DUT to the model.
    always @(negedge clk) begin
        checkOutput("cyc_we", {31'd0, we}, {31'd0, m_we});
        checkOutput("cyc_waddr", {16'd0, waddr}, {16'd0, m_addr});
        checkOutput("cyc_wdata", {16'd0, wdata}, {16'd0, m_data});
        checkOutput("cyc_src_dbg", {31'd0, src_dbg}, {31'd0, m_src});
        checkOutput("cyc_level", {29'd0, fifo_level}, q.size());
        checkOutput("cyc_overflow", {31'd0, overflow}, {31'd0, m_ovf});
    end

    // Drive one cycle of inputs, then advance to just after the next edge.
    task automatic applyStimulus(input logic c_we, input logic [15:0] c_a, input logic [15:0] c_d,
                                 input logic d_we, input logic [15:0] d_a, input logic [15:0] d_d,
                                 input logic clr);
        cpu_we = c_we;
        cpu_waddr = c_a;
        cpu_wdata = c_d;
        dbg_we = d_we;
        dbg_waddr = d_a;
        dbg_wdata = d_d;
        ovf_clr = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        applyStimulus(1'b0, 16'h0, 16'h0, 1'b0, 16'h0, 16'h0, 1'b0);
    endtask

    initial begin
        #2;
        checkOutput("reset_we", {31'd0, we}, 32'd0);
        checkOutput("reset_level", {29'd0, fifo_level}, 32'd0);
        checkOutput("reset_overflow", {31'd0, overflow}, 32'd0);
        repeat (2) @(posedge clk);
        #2 reset_n = 1'b1;
        @(posedge clk);
        #1;

        // 1: single cpu write, latency 1
        applyStimulus(1'b1, 16'h0010, 16'hBEEF, 1'b0, 16'h0, 16'h0, 1'b0);
        checkOutput("t1_we", {31'd0, we}, 32'd1);
        checkOutput("t1_waddr", {16'd0, waddr}, 32'h0010);
        checkOutput("t1_wdata", {16'd0, wdata}, 32'hBEEF);
        checkOutput("t1_src", {31'd0, src_dbg}, 32'd0);
        idle();
        checkOutput("t1_idle_we", {31'd0, we}, 32'd0);
        checkOutput("t1_hold_addr", {16'd0, waddr}, 32'h0010);

        // 2: single debug write, latency 2
        applyStimulus(1'b0, 16'h0, 16'h0, 1'b1, 16'h8005, 16'h0041, 1'b0);
        checkOutput("t2_we_early", {31'd0, we}, 32'd0);
        checkOutput("t2_level_1", {29'd0, fifo_level}, 32'd1);
        idle();
        checkOutput("t2_we", {31'd0, we}, 32'd1);
        checkOutput("t2_src", {31'd0, src_dbg}, 32'd1);
        checkOutput("t2_waddr", {16'd0, waddr}, 32'h8005);
        checkOutput("t2_wdata", {16'd0, wdata}, 32'h0041);
        checkOutput("t2_level_0", {29'd0, fifo_level}, 32'd0);
        idle();

        // 3: cpu held 8 cycles with 3 debug pulses
        for (int i = 0; i < 8; i++) begin
            if (i == 1 || i == 3 || i == 5)
                applyStimulus(1'b1, 16'h0100 + 16'(i), 16'h1000 + 16'(i), 1'b1, 16'hF000 + 16'(i), 16'h2000 + 16'(i), 1'b0);
            else
                applyStimulus(1'b1, 16'h0100 + 16'(i), 16'h1000 + 16'(i), 1'b0, 16'h0, 16'h0, 1'b0);
        end
        checkOutput("t3_level_peak", {29'd0, fifo_level}, 32'd3);
        checkOutput("t3_last_cpu", {16'd0, waddr}, 32'h0107);
        idle();
        checkOutput("t3_first_dbg", {16'd0, waddr}, 32'hF001);
        idle();
        checkOutput("t3_second_dbg", {16'd0, waddr}, 32'hF003);
        idle();
        checkOutput("t3_third_dbg", {16'd0, waddr}, 32'hF005);
        idle();
        checkOutput("t3_drained", {29'd0, fifo_level}, 32'd0);

        // 4: cpu held, 5 debug pulses -> fifth dropped
        for (int i = 0; i < 5; i++)
            applyStimulus(1'b1, 16'h0200 + 16'(i), 16'h3000 + 16'(i), 1'b1, 16'h8100 + 16'(i), 16'h4000 + 16'(i), 1'b0);
        checkOutput("t4_level_full", {29'd0, fifo_level}, 32'd4);
        checkOutput("t4_overflow", {31'd0, overflow}, 32'd1);
`ifdef MEM_WRITE_ARB_STATS_EN
        checkOutput("t4_drop_cnt", {16'd0, dbg_drop_cnt}, 32'd1);
`endif
        applyStimulus(1'b1, 16'h0210, 16'h5555, 1'b0, 16'h0, 16'h0, 1'b1);
        checkOutput("t4_ovf_cleared", {31'd0, overflow}, 32'd0);
        applyStimulus(1'b1, 16'h0211, 16'h6666, 1'b1, 16'h8FFF, 16'hDEAD, 1'b1);
        checkOutput("t4_set_wins", {31'd0, overflow}, 32'd1);
        applyStimulus(1'b1, 16'h0212, 16'h7777, 1'b0, 16'h0, 16'h0, 1'b1);
        checkOutput("t4_ovf_cleared2", {31'd0, overflow}, 32'd0);

        // 5: full FIFO, push and pop in the same cycle
        applyStimulus(1'b0, 16'h0, 16'h0, 1'b1, 16'h8200, 16'hCAFE, 1'b0);
        checkOutput("t5_level", {29'd0, fifo_level}, 32'd4);
        checkOutput("t5_no_ovf", {31'd0, overflow}, 32'd0);
        checkOutput("t5_pop_addr", {16'd0, waddr}, 32'h8100);
        checkOutput("t5_pop_src", {31'd0, src_dbg}, 32'd1);

        // 6: reset mid-drain
        idle();
        checkOutput("t6_level_3", {29'd0, fifo_level}, 32'd3);
        #1 reset_n = 1'b0;
        #1;
        checkOutput("t6_rst_we", {31'd0, we}, 32'd0);
        checkOutput("t6_rst_waddr", {16'd0, waddr}, 32'd0);
        checkOutput("t6_rst_wdata", {16'd0, wdata}, 32'd0);
        checkOutput("t6_rst_level", {29'd0, fifo_level}, 32'd0);
        checkOutput("t6_rst_src", {31'd0, src_dbg}, 32'd0);
        @(posedge clk);
        #2 reset_n = 1'b1;
        @(posedge clk);
        #1;
        repeat (3) idle();
        checkOutput("t6_no_beat", {31'd0, we}, 32'd0);
        checkOutput("t6_level_after", {29'd0, fifo_level}, 32'd0);

        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
